// File: rtl/rambus_burst.sv
// Wishbone B4 scratch-RAM slave: byte-enabled writes, programmable wait states,
// out-of-range error termination and registered-feedback incrementing bursts.
module rambus_burst #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 128,
  parameter int READ_WAIT  = 0
) (
  input  logic                    rambus_wb_clk_i,
  input  logic                    rambus_wb_rst_i,
  input  logic                    rambus_wb_cyc_i,
  input  logic                    rambus_wb_stb_i,
  input  logic                    rambus_wb_we_i,
  input  logic [DATA_WIDTH/8-1:0] rambus_wb_sel_i,
  input  logic [DATA_WIDTH-1:0]   rambus_wb_dat_i,
  input  logic [ADDR_WIDTH-1:0]   rambus_wb_addr_i,
  input  logic [2:0]              rambus_wb_cti_i,
  input  logic [1:0]              rambus_wb_bte_i,
  output logic                    rambus_wb_ack_o,
  output logic                    rambus_wb_err_o,
  output logic [DATA_WIDTH-1:0]   rambus_wb_dat_o
);

  localparam int SEL = DATA_WIDTH / 8;
  localparam int LSB = $clog2(SEL);
  localparam int IW  = ADDR_WIDTH - LSB;
  localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]  CTI_INC   = 3'b010;
  localparam logic [2:0]  CTI_EOB   = 3'b111;
  localparam logic [1:0]  WAIT_LAST = (READ_WAIT > 0) ? 2'(READ_WAIT - 1) : 2'd0;
  localparam logic [IW:0] DEPTH_IDX = (IW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ACK   = 2'd2,
    BURST = 2'd3
  } state_t;

  // Handshake: a beat is requested while cyc&stb are high and completes at the
  // clock edge that raises ack (or err); the termination is a registered
  // one-cycle pulse per beat. New transactions are taken only from IDLE with
  // ack and err both low, so back-to-back classic requests are acked every
  // other cycle at best.
  state_t state, state_c, state_d;

  logic                  clk;
  logic                  rst;
  logic                  we_q;
  logic [IW-1:0]         idx_q;
  logic [2:0]            cti_q;
  logic [1:0]            bte_q;
  logic [1:0]            wait_cnt;
  logic                  accept;
  logic                  beat;
  logic                  beat_we;
  logic                  beat_ok;
  logic                  oor;
  logic [IW-1:0]         addr_idx;
  logic [IW-1:0]         beat_idx;
  logic [IW-1:0]         inc_idx;
  logic [IW-1:0]         wrap_mask;
  logic [IW-1:0]         next_idx;
  logic [MW-1:0]         mem_idx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign clk      = rambus_wb_clk_i;
  assign rst      = rambus_wb_rst_i;
  assign addr_idx = rambus_wb_addr_i[ADDR_WIDTH-1:LSB];

  if (LSB > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^rambus_wb_addr_i[LSB-1:0];
  end

  // Wrap bursts hold the upper index bits; linear uses an all-ones mask.
  always_comb begin
    case (bte_q)
      2'b01:   wrap_mask = IW'(3);
      2'b10:   wrap_mask = IW'(7);
      2'b11:   wrap_mask = IW'(15);
      default: wrap_mask = '1;
    endcase
  end

  assign inc_idx  = idx_q + IW'(1);
  assign next_idx = (idx_q & ~wrap_mask) | (inc_idx & wrap_mask);

  always_comb begin
    state_c  = state;
    accept   = 1'b0;
    beat     = 1'b0;
    beat_idx = idx_q;
    beat_we  = we_q;
    case (state)
      IDLE: begin
        if (rambus_wb_cyc_i && rambus_wb_stb_i && !rambus_wb_ack_o && !rambus_wb_err_o) begin
          accept = 1'b1;
          if (READ_WAIT == 0) begin
            beat     = 1'b1;
            beat_idx = addr_idx;
            beat_we  = rambus_wb_we_i;
            state_c  = (rambus_wb_cti_i == CTI_INC) ? BURST : ACK;
          end else begin
            state_c = WAIT;
          end
        end
      end
      WAIT: begin
        if (!rambus_wb_cyc_i) begin
          state_c = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          beat    = 1'b1;
          state_c = (cti_q == CTI_INC) ? BURST : ACK;
        end
      end
      ACK: begin
        state_c = IDLE;
      end
      BURST: begin
        if (!rambus_wb_cyc_i) begin
          state_c = IDLE;
        end else if (rambus_wb_stb_i) begin
          beat     = 1'b1;
          beat_idx = next_idx;
          if (rambus_wb_cti_i == CTI_EOB) state_c = IDLE;
        end
      end
      default: state_c = IDLE;
    endcase
  end

  assign oor     = {1'b0, beat_idx} >= DEPTH_IDX;
  assign beat_ok = beat & ~oor;
  assign mem_idx = beat_idx[MW-1:0];
  // An error beat ends a burst outright.
  assign state_d = (beat && oor && state_c == BURST) ? IDLE : state_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      rambus_wb_ack_o <= 1'b0;
      rambus_wb_err_o <= 1'b0;
      rambus_wb_dat_o <= '0;
      we_q            <= 1'b0;
      idx_q           <= '0;
      cti_q           <= '0;
      bte_q           <= '0;
      wait_cnt        <= '0;
    end else begin
      state           <= state_d;
      rambus_wb_ack_o <= beat_ok;
      rambus_wb_err_o <= beat & oor;
      if (beat_ok && !beat_we) rambus_wb_dat_o <= mem[mem_idx];
      if (accept) begin
        we_q     <= rambus_wb_we_i;
        idx_q    <= addr_idx;
        cti_q    <= rambus_wb_cti_i;
        bte_q    <= rambus_wb_bte_i;
        wait_cnt <= '0;
      end else if (state == WAIT && !beat) begin
        wait_cnt <= wait_cnt + 2'd1;
      end
      if (beat) idx_q <= beat_idx;
    end
  end

  // Storage is never cleared; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (beat_ok && beat_we && !rst) begin
      for (int b = 0; b < SEL; b++) begin
        if (rambus_wb_sel_i[b]) mem[mem_idx][8*b +: 8] <= rambus_wb_dat_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_rambus_burst.sv
// Bench for rambus_burst: a zero-wait DEPTH=100 instance and a READ_WAIT=2
// instance share one master; a word-array model predicts every beat.
module tb_rambus_burst;
  localparam int DEPTH0 = 100;
  localparam logic [2:0] CTI_CLS = 3'b000;
  localparam logic [2:0] CTI_INC = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;

  typedef struct {
    logic        w;
    logic [8:0]  a;
    logic [3:0]  s;
    logic [31:0] d;
    logic        e_ack;
    logic        e_err;
    logic [31:0] e_dat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        tgt  = 1'b0;
  logic        cyc  = 1'b0;
  logic        stb  = 1'b0;
  logic        we   = 1'b0;
  logic [3:0]  sel  = '0;
  logic [31:0] wdat = '0;
  logic [8:0]  addr = '0;
  logic [2:0]  cti  = '0;
  logic [1:0]  bte  = '0;
  logic        cyc0, cyc1, ack0, ack1, err0, err1, ack, err;
  logic [31:0] dat0, dat1, rdat;

  assign cyc0 = cyc & ~tgt;
  assign cyc1 = cyc & tgt;
  assign ack  = tgt ? ack1 : ack0;
  assign err  = tgt ? err1 : err0;
  assign rdat = tgt ? dat1 : dat0;

  rambus_burst #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH(100), .READ_WAIT(0)) dut (
    .rambus_wb_clk_i(clk), .rambus_wb_rst_i(rst), .rambus_wb_cyc_i(cyc0),
    .rambus_wb_stb_i(stb), .rambus_wb_we_i(we), .rambus_wb_sel_i(sel),
    .rambus_wb_dat_i(wdat), .rambus_wb_addr_i(addr), .rambus_wb_cti_i(cti),
    .rambus_wb_bte_i(bte), .rambus_wb_ack_o(ack0), .rambus_wb_err_o(err0),
    .rambus_wb_dat_o(dat0)
  );

  rambus_burst #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH(128), .READ_WAIT(2)) dut_w (
    .rambus_wb_clk_i(clk), .rambus_wb_rst_i(rst), .rambus_wb_cyc_i(cyc1),
    .rambus_wb_stb_i(stb), .rambus_wb_we_i(we), .rambus_wb_sel_i(sel),
    .rambus_wb_dat_i(wdat), .rambus_wb_addr_i(addr), .rambus_wb_cti_i(cti),
    .rambus_wb_bte_i(bte), .rambus_wb_ack_o(ack1), .rambus_wb_err_o(err1),
    .rambus_wb_dat_o(dat1)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_mem [128];
  logic [31:0] exp_dout = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic model_write(input int idx, input logic [3:0] s, input logic [31:0] d);
    for (int b = 0; b < 4; b++) if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  // Index of beat k of a burst starting at word start.
  function automatic int burst_idx(input int start, input logic [1:0] b, input int k);
    int n;
    case (b)
      2'b00:   return start + k;
      2'b01:   n = 4;
      2'b10:   n = 8;
      default: n = 16;
    endcase
    return (start / n) * n + ((start % n) + k) % n;
  endfunction

  task automatic beat_data(input int mode, input int k);
    case (mode)
      0:       begin wdat = $urandom; sel = 4'hF; end
      1:       begin wdat = $urandom; sel = 4'($urandom_range(1, 15)); end
      default: begin wdat = 32'(k + 1); sel = 4'hF; end
    endcase
  endtask

  // Called just after a rising edge; returns one step after the bus is idle.
  task automatic wb_classic(input logic w, input logic [8:0] a, input logic [3:0] s,
                            input logic [31:0] d, output logic g_ack, output logic g_err,
                            output logic [31:0] g_dat, output int lat);
    we = w; addr = a; sel = s; wdat = d; cti = CTI_CLS; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    g_ack = 1'b0; g_err = 1'b0; g_dat = '0; lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); @(negedge clk);
      if (ack || err) begin
        g_ack = ack; g_err = err; g_dat = rdat; lat = i;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); @(negedge clk);
    check("pulse_width", {30'b0, ack, err}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic classic_model(input logic w, input int idx, input logic [1:0] lo,
                               input logic [3:0] s, input logic [31:0] d, input string tag);
    logic a_ack, a_err, exp_err;
    logic [31:0] a_dat;
    int lat;
    exp_err = (idx >= DEPTH0);
    wb_classic(w, {idx[6:0], lo}, s, d, a_ack, a_err, a_dat, lat);
    if (!exp_err) begin
      if (w) model_write(idx, s, d);
      else exp_dout = model_mem[idx];
    end
    check({tag, "_ack"}, 32'(a_ack), 32'(!exp_err));
    check({tag, "_err"}, 32'(a_err), 32'(exp_err));
    check({tag, "_dat"}, a_dat, exp_dout);
    check({tag, "_lat"}, 32'(lat), 32'd1);
  endtask

  task automatic wb_burst(input logic w, input int start, input logic [1:0] b, input int n,
                          input int gap_after, input int mode, input string tag,
                          output int nbeats, output logic last_err);
    int cyc_cnt, idx, gaps;
    logic done, exp_err;
    cyc_cnt = 0; gaps = 0; done = 1'b0; nbeats = 0; last_err = 1'b0;
    we = w; addr = 9'(start * 4); bte = b; cti = (n == 1) ? CTI_EOB : CTI_INC;
    beat_data(mode, 0);
    cyc = 1'b1; stb = 1'b1;
    while (!done) begin
      @(posedge clk); @(negedge clk);
      cyc_cnt++;
      if (ack || err) begin
        idx = burst_idx(start, b, nbeats);
        exp_err = (idx >= DEPTH0);
        if (!exp_err && !w) exp_dout = model_mem[idx];
        if (!exp_err && w) model_write(idx, sel, wdat);
        check({tag, "_ack"}, 32'(ack), 32'(!exp_err));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_dat"}, rdat, exp_dout);
        check({tag, "_cycle"}, 32'(cyc_cnt), 32'(nbeats + 1 + gaps));
        nbeats++;
        last_err = err;
        if (err || exp_err || nbeats == n) begin
          done = 1'b1;
        end else begin
          cti = (nbeats == n - 1) ? CTI_EOB : CTI_INC;
          beat_data(mode, nbeats);
          if (nbeats == gap_after) begin
            stb = 1'b0;
            @(posedge clk); @(negedge clk);
            cyc_cnt++; gaps++;
            check({tag, "_gap"}, {30'b0, ack, err}, 32'd0);
            stb = 1'b1;
          end
        end
      end else if (cyc_cnt > n + 4) begin
        check({tag, "_timeout"}, 32'(nbeats), 32'(n));
        done = 1'b1;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); @(negedge clk);
    check({tag, "_end"}, {30'b0, ack, err}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    logic a_ack, a_err, le, seen;
    logic [31:0] a_dat;
    int lat, nb, widx[4];
    vecs[0] = '{1'b1, 9'h010, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 9'h010, 4'h1, 32'h000000AA, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 9'h010, 4'hF, 32'h0,        1'b1, 1'b0, 32'hDEADBEAA};
    vecs[3] = '{1'b0, 9'h190, 4'hF, 32'h0,        1'b0, 1'b1, 32'hDEADBEAA};
    vecs[4] = '{1'b1, 9'h18C, 4'hF, 32'h12345678, 1'b1, 1'b0, 32'hDEADBEAA};
    vecs[5] = '{1'b1, 9'h18C, 4'hA, 32'hAABBCCDD, 1'b1, 1'b0, 32'hDEADBEAA};
    vecs[6] = '{1'b0, 9'h18C, 4'hF, 32'h0,        1'b1, 1'b0, 32'hAA34CC78};
    vecs[7] = '{1'b1, 9'h1FC, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hAA34CC78};
    vecs[8] = '{1'b1, 9'h012, 4'h4, 32'h00550000, 1'b1, 1'b0, 32'hAA34CC78};
    vecs[9] = '{1'b0, 9'h013, 4'hF, 32'h0,        1'b1, 1'b0, 32'hDE55BEAA};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", 32'(ack0), 32'd0);
    check("reset_err", 32'(err0), 32'd0);
    check("reset_dat", dat0, 32'd0);
    check("reset_w_outs", {30'b0, ack1, err1}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      wb_classic(vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, a_ack, a_err, a_dat, lat);
      check($sformatf("vec%0d_ack", i), 32'(a_ack), 32'(vecs[i].e_ack));
      check($sformatf("vec%0d_err", i), 32'(a_err), 32'(vecs[i].e_err));
      check($sformatf("vec%0d_dat", i), a_dat, vecs[i].e_dat);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
      if (vecs[i].e_ack && vecs[i].w) model_write(int'(vecs[i].a >> 2), vecs[i].s, vecs[i].d);
    end
    exp_dout = 32'hDE55BEAA;

    wb_burst(1'b1, 0, 2'b00, DEPTH0, -1, 0, "init", nb, le);
    check("init_beats", 32'(nb), 32'(DEPTH0));
    wb_burst(1'b0, 0, 2'b00, 4, -1, 0, "lin4", nb, le);
    check("lin4_beats", 32'(nb), 32'd4);

    wb_burst(1'b1, 6, 2'b01, 4, -1, 2, "wrap4w", nb, le);
    widx = '{6, 7, 4, 5};
    for (int k = 0; k < 4; k++) begin
      wb_classic(1'b0, 9'(widx[k] * 4), 4'hF, 32'h0, a_ack, a_err, a_dat, lat);
      exp_dout = 32'(k + 1);
      check($sformatf("wrap4_word%0d", widx[k]), a_dat, exp_dout);
    end
    wb_burst(1'b0, 6, 2'b01, 4, -1, 0, "wrap4r", nb, le);

    wb_burst(1'b0, 98, 2'b00, 4, -1, 0, "lin98", nb, le);
    check("lin98_beats", 32'(nb), 32'd3);
    check("lin98_last_err", 32'(le), 32'd1);

    wb_burst(1'b1, 20, 2'b10, 6, 2, 1, "gapw", nb, le);
    wb_burst(1'b0, 20, 2'b10, 8, 3, 0, "gapr", nb, le);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        classic_model(1'($urandom_range(0, 1)), int'($urandom_range(0, 103)),
                      2'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), $urandom,
                      $sformatf("rnd%0d_cls", it));
      end else begin
        wb_burst(1'($urandom_range(0, 1)), int'($urandom_range(0, 103)),
                 2'($urandom_range(0, 3)), int'($urandom_range(1, 8)),
                 ($urandom_range(0, 1) == 1) ? 1 : -1, 1,
                 $sformatf("rnd%0d_bst", it), nb, le);
      end
    end

    // Asynchronous reset in the middle of a burst with stb held.
    tgt = 1'b0; we = 1'b0; addr = 9'(10 * 4); cti = CTI_INC; bte = 2'b00; sel = 4'hF;
    cyc = 1'b1; stb = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_pre_ack", 32'(ack), 32'd1);
    check("rst_pre_dat", rdat, model_mem[10]);
    #2 rst = 1'b1;
    #1;
    check("rst_async_ack", 32'(ack), 32'd0);
    check("rst_async_err", 32'(err), 32'd0);
    check("rst_async_dat", rdat, 32'd0);
    @(posedge clk); @(negedge clk);
    check("rst_held_outs", {30'b0, ack, err}, 32'd0);
    cyc = 1'b0; stb = 1'b0; rst = 1'b0; exp_dout = '0;
    @(posedge clk); #1;
    classic_model(1'b0, 10, 2'b00, 4'hF, 32'h0, "post_rst");

    // Wait-state instance: latency and abort during WAIT.
    tgt = 1'b1;
    wb_classic(1'b1, 9'h004, 4'hF, 32'hCAFE0004, a_ack, a_err, a_dat, lat);
    check("w_wr4_ack", 32'(a_ack), 32'd1);
    check("w_wr4_lat", 32'(lat), 32'd3);
    wb_classic(1'b1, 9'h008, 4'hF, 32'h11111111, a_ack, a_err, a_dat, lat);
    check("w_wr8_lat", 32'(lat), 32'd3);
    we = 1'b1; addr = 9'h008; wdat = 32'h22222222; sel = 4'hF; cti = CTI_CLS;
    cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | ack | err;
    end
    check("w_abort_no_term", 32'(seen), 32'd0);
    @(posedge clk); #1;
    wb_classic(1'b0, 9'h004, 4'hF, 32'h0, a_ack, a_err, a_dat, lat);
    check("w_rd4_ack", 32'(a_ack), 32'd1);
    check("w_rd4_err", 32'(a_err), 32'd0);
    check("w_rd4_dat", a_dat, 32'hCAFE0004);
    check("w_rd4_lat", 32'(lat), 32'd3);
    wb_classic(1'b0, 9'h008, 4'hF, 32'h0, a_ack, a_err, a_dat, lat);
    check("w_rd8_dat", a_dat, 32'h11111111);
    check("w_rd8_lat", 32'(lat), 32'd3);
    tgt = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
